// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the cascoded tree arbiter.
//   PRIO_R1 / PRIO_R2         : client indices held in the `last` pointer
//   GNT_NONE / GNT_1 / GNT_2  : 2-bit grant encoding {grant2, grant1}
//   grant_for()               : maps a client index to its grant code
// -----------------------------------------------------------------------------
package arb_pkg;

   localparam logic PRIO_R1 = 1'b0;
   localparam logic PRIO_R2 = 1'b1;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_1    = 2'b01;
   localparam logic [1:0] GNT_2    = 2'b10;

   // Grant code for the client identified by prio.
   function automatic logic [1:0] grant_for(input logic prio);
      return (prio == PRIO_R2) ? GNT_2 : GNT_1;
   endfunction

endpackage : arb_pkg

// File: rtl/arb_node2.sv
// -----------------------------------------------------------------------------
// arb_node2
// Two-input round-robin arbitration node with a registered one-hot-or-zero
// grant. The holder keeps the grant for as long as it requests; under
// contention the client that was not granted most recently wins.
//   clk, rst      : clock, asynchronous active-high reset
//   req1, req2    : level requests from the two children
//   gnt_down      : permission from the parent node (1 = may grant)
//   req_up        : OR of the child requests, presented to the parent
//   gnt1, gnt2    : registered grants to the children
// -----------------------------------------------------------------------------
module arb_node2
   import arb_pkg::*;
#(
   parameter int unsigned INIT_PRIO = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic req1,
   input  logic req2,
   input  logic gnt_down,
   output logic req_up,
   output logic gnt1,
   output logic gnt2
);

   // `last` starts on the opposite client so the first contention favours
   // INIT_PRIO.
   localparam logic LAST_RST = (INIT_PRIO == 0) ? PRIO_R2 : PRIO_R1;

   logic [1:0] gnt_r;
   logic [1:0] gnt_next_s;
   logic       last_r;
   logic       last_next_s;

   assign req_up = req1 | req2;
   assign gnt1   = gnt_r[0];
   assign gnt2   = gnt_r[1];

   // Next grant and priority pointer, first matching rule wins.
   always_comb begin
      gnt_next_s  = GNT_NONE;
      last_next_s = last_r;
      if (gnt_down == 1'b0) begin
         gnt_next_s = GNT_NONE;
      end else if ((gnt_r == GNT_1) && req1) begin
         gnt_next_s = gnt_r;
      end else if ((gnt_r == GNT_2) && req2) begin
         gnt_next_s = gnt_r;
      end else begin
         // Holder gone (or idle): a waiting client takes over on this same
         // edge, so a handover has no idle cycle.
         case ({req2, req1})
            2'b01:   gnt_next_s = GNT_1;
            2'b10:   gnt_next_s = GNT_2;
            2'b11:   gnt_next_s = grant_for(~last_r);
            default: gnt_next_s = GNT_NONE;
         endcase
      end
      // The pointer moves only when a grant is newly issued, not while held.
      if ((gnt_next_s != GNT_NONE) && (gnt_next_s != gnt_r)) begin
         last_next_s = (gnt_next_s == GNT_2) ? PRIO_R2 : PRIO_R1;
      end else begin
         last_next_s = last_r;
      end
   end

   // Grant register and priority pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_r  <= GNT_NONE;
         last_r <= LAST_RST;
      end else begin
         gnt_r  <= gnt_next_s;
         last_r <= last_next_s;
      end
   end

endmodule : arb_node2

// File: rtl/cascoded_tree_arbiter.sv
// -----------------------------------------------------------------------------
// cascoded_tree_arbiter
// Two-client mutual-exclusion arbiter built from a single root arb_node2.
//   INIT_PRIO : client favoured on the first contention (0 = R1, 1 = R2)
//   clk, rst  : clock, asynchronous active-high reset
//   R1, R2    : level requests from client 1 / client 2
//   A1, A2    : registered grants, never both high
// -----------------------------------------------------------------------------
module cascoded_tree_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned INIT_PRIO = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic R1,
   input  logic R2,
   output logic A1,
   output logic A2
);

   // The root has no parent: its permission is tied high and its request
   // summary has no consumer.
   arb_node2 #(
      .INIT_PRIO (INIT_PRIO)
   ) u_root (
      .clk      (clk),
      .rst      (rst),
      .req1     (R1),
      .req2     (R2),
      .gnt_down (1'b1),
      .req_up   (),
      .gnt1     (A1),
      .gnt2     (A2)
   );

endmodule : cascoded_tree_arbiter

// File: tb/tb_cascoded_tree_arbiter.sv
module tb_cascoded_tree_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic r1  = 1'b0;
   logic r2  = 1'b0;
   logic a1_0, a2_0, a1_1, a2_1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state per instance: owner 0 = nobody, 1 = client 1, 2 = client 2.
   int owner [2];
   int last_cl [2];

   always #5 clk = ~clk;

   cascoded_tree_arbiter #(.INIT_PRIO(0)) dut0 (
      .clk(clk), .rst(rst), .R1(r1), .R2(r2), .A1(a1_0), .A2(a2_0)
   );

   cascoded_tree_arbiter #(.INIT_PRIO(1)) dut1 (
      .clk(clk), .rst(rst), .R1(r1), .R2(r2), .A1(a1_1), .A2(a2_1)
   );

   task automatic model_reset();
      owner[0] = 0; last_cl[0] = 2;   // favours client 1 first
      owner[1] = 0; last_cl[1] = 1;   // favours client 2 first
   endtask

   task automatic model_edge(input logic q1, input logic q2);
      for (int i = 0; i < 2; i++) begin
         int nxt;
         if (owner[i] == 1 && q1)      nxt = 1;
         else if (owner[i] == 2 && q2) nxt = 2;
         else if (q1 && q2)            nxt = (last_cl[i] == 1) ? 2 : 1;
         else if (q1)                  nxt = 1;
         else if (q2)                  nxt = 2;
         else                          nxt = 0;
         if (nxt != 0 && nxt != owner[i]) last_cl[i] = nxt;
         owner[i] = nxt;
      end
   endtask

   function automatic logic [1:0] exp_g(input int i);
      if (owner[i] == 1) return 2'b01;
      if (owner[i] == 2) return 2'b10;
      return 2'b00;
   endfunction

   // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
   task automatic cycle(input logic q1, input logic q2);
      @(negedge clk);
      r1 = q1;
      r2 = q2;
      @(posedge clk);
      if (!rst) model_edge(q1, q2);
      #1;
   endtask

   task automatic release_cycle(input logic q1, input logic q2);
      @(negedge clk);
      rst = 1'b0;
      r1 = q1;
      r2 = q2;
      @(posedge clk);
      model_edge(q1, q2);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 1'b1);
         n_cmp++;
         if ({a2_0, a1_0, a2_1, a1_1} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_hold: got {A2,A1} inst0=%b inst1=%b, want 00/00",
                     {a2_0, a1_0}, {a2_1, a1_1});
         end
      end
   endtask

   task automatic test_contention();
      release_cycle(1'b1, 1'b1);
      n_cmp++;
      if ({a2_0, a1_0} !== 2'b01 || {a2_1, a1_1} !== 2'b10) begin
         n_err++;
         $display("FAIL first_contention: got inst0=%b inst1=%b, want 01/10",
                  {a2_0, a1_0}, {a2_1, a1_1});
      end
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 1'b1);
         n_cmp++;
         if ({a2_0, a1_0} !== 2'b01 || {a2_1, a1_1} !== 2'b10) begin
            n_err++;
            $display("FAIL contention_hold[%0d]: got inst0=%b inst1=%b, want 01/10",
                     k, {a2_0, a1_0}, {a2_1, a1_1});
         end
      end
   endtask

   task automatic test_handover();
      cycle(1'b0, 1'b1);
      n_cmp++;
      if ({a2_0, a1_0} !== 2'b10 || {a2_1, a1_1} !== 2'b10) begin
         n_err++;
         $display("FAIL handover: got inst0=%b inst1=%b, want 10/10",
                  {a2_0, a1_0}, {a2_1, a1_1});
      end
      cycle(1'b0, 1'b0);
      n_cmp++;
      if ({a2_0, a1_0, a2_1, a1_1} !== 4'b0000) begin
         n_err++;
         $display("FAIL handover_release: got inst0=%b inst1=%b, want 00/00",
                  {a2_0, a1_0}, {a2_1, a1_1});
      end
   endtask

   task automatic test_single();
      for (int k = 0; k < 4; k++) begin
         cycle(1'b1, 1'b0);
         n_cmp++;
         if ({a2_0, a1_0} !== 2'b01 || {a2_1, a1_1} !== 2'b01) begin
            n_err++;
            $display("FAIL single_r1[%0d]: got inst0=%b inst1=%b, want 01/01",
                     k, {a2_0, a1_0}, {a2_1, a1_1});
         end
      end
      cycle(1'b0, 1'b0);
      n_cmp++;
      if ({a2_0, a1_0, a2_1, a1_1} !== 4'b0000) begin
         n_err++;
         $display("FAIL single_drop: got inst0=%b inst1=%b, want 00/00",
                  {a2_0, a1_0}, {a2_1, a1_1});
      end
   endtask

   task automatic test_round_robin();
      int prev;
      cycle(1'b1, 1'b1);
      prev = owner[0];
      for (int k = 0; k < 8; k++) begin
         // The current inst0 holder pulses its request low for one cycle.
         if (prev == 1) cycle(1'b0, 1'b1);
         else           cycle(1'b1, 1'b0);
         n_cmp++;
         if ({a2_0, a1_0} !== ((prev == 1) ? 2'b10 : 2'b01) ||
             {a2_1, a1_1} !== exp_g(1)) begin
            n_err++;
            $display("FAIL round_robin[%0d]: got inst0=%b inst1=%b, want %b/%b",
                     k, {a2_0, a1_0}, {a2_1, a1_1},
                     (prev == 1) ? 2'b10 : 2'b01, exp_g(1));
         end
         prev = (prev == 1) ? 2 : 1;
         cycle(1'b1, 1'b1);
         n_cmp++;
         if ({a2_0, a1_0} !== exp_g(0) || {a2_1, a1_1} !== exp_g(1) ||
             (a1_0 & a2_0) || (a1_1 & a2_1)) begin
            n_err++;
            $display("FAIL round_robin_hold[%0d]: got inst0=%b inst1=%b, want %b/%b",
                     k, {a2_0, a1_0}, {a2_1, a1_1}, exp_g(0), exp_g(1));
         end
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 1'b0);
      n_cmp++;
      if (a1_0 !== 1'b1 || a1_1 !== 1'b1) begin
         n_err++;
         $display("FAIL async_pre: got A1 inst0=%b inst1=%b, want 1/1", a1_0, a1_1);
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if ({a2_0, a1_0, a2_1, a1_1} !== 4'b0000) begin
         n_err++;
         $display("FAIL async_reset: got inst0=%b inst1=%b before any edge, want 00/00",
                  {a2_0, a1_0}, {a2_1, a1_1});
      end
      cycle(1'b1, 1'b0);
      n_cmp++;
      if ({a2_0, a1_0, a2_1, a1_1} !== 4'b0000) begin
         n_err++;
         $display("FAIL async_reset_hold: got inst0=%b inst1=%b, want 00/00",
                  {a2_0, a1_0}, {a2_1, a1_1});
      end
      release_cycle(1'b1, 1'b0);
      n_cmp++;
      if ({a2_0, a1_0} !== 2'b01 || {a2_1, a1_1} !== 2'b01) begin
         n_err++;
         $display("FAIL reset_release_grant: got inst0=%b inst1=%b, want 01/01",
                  {a2_0, a1_0}, {a2_1, a1_1});
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         logic q1, q2;
         q1 = ($urandom_range(0, 3) != 0);
         q2 = ($urandom_range(0, 3) != 0);
         cycle(q1, q2);
         n_cmp++;
         if ({a2_0, a1_0} !== exp_g(0) || {a2_1, a1_1} !== exp_g(1) ||
             (a1_0 & a2_0) || (a1_1 & a2_1)) begin
            n_err++;
            $display("FAIL random[%0d] R=%b%b: got inst0=%b inst1=%b, want %b/%b",
                     k, q2, q1, {a2_0, a1_0}, {a2_1, a1_1}, exp_g(0), exp_g(1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_handover();
      test_single();
      test_round_robin();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_cascoded_tree_arbiter
